cm_merge: RTL and testbench

- Streaming two-way merge of pre-sorted element streams, e.g. two cm_sort output vectors serialized into element streams.
- Consumes one frame from each input. Emits a single sorted frame at up to one element per clock.
- Sits downstream of the sort networks. Combines sorted runs larger than one network width.
- Valid/ready handshake on all three streams; registered output.

---
 rtl/cm_merge_pkg.sv | 21 ++
 rtl/cm_merge_cmp.sv | 27 ++
 rtl/cm_merge.sv | 144 ++++++++++++++
 tb/tb_cm_merge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cm_merge_pkg.sv
// Shared types for the two-way sorted-stream merge.
// Holds the merge FSM state encoding and the parameter integer type,
// so the top and any future N-way merge tree agree on both.
package cm_merge_pkg;

  // Unsigned 32-bit type used for all module parameters.
  typedef logic [31:0] u32;

  // MERGE   : both streams still have elements; compare heads.
  // DRAIN_A : B frame fully consumed; pass remaining A elements.
  // DRAIN_B : A frame fully consumed; pass remaining B elements.
  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  localparam u32 CM_DWIDTH_DEF  = 32'd8;
  localparam u32 CM_DESCEND_DEF = 32'd0;

endpackage

// File: rtl/cm_merge_cmp.sv
// Compare/select for one merge node: decides whether head A goes before head B.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: a, b = unsigned heads; pick_a = 1 when A should be emitted first.
// Ties always favour A so a merge built from these nodes stays stable.
module cm_merge_cmp
  import cm_merge_pkg::*;
#(
  parameter u32 DWIDTH  = CM_DWIDTH_DEF,
  parameter u32 DESCEND = CM_DESCEND_DEF
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              pick_a
);

  always_comb begin
    pick_a = 1'b0;
    if (DESCEND != 32'd0) begin
      // Largest first; equality keeps A ahead of B.
      pick_a = (a >= b);
    end else begin
      // Smallest first; equality keeps A ahead of B.
      pick_a = (a <= b);
    end
  end

endmodule

// File: rtl/cm_merge.sv
// Streaming two-way merge of pre-sorted frames A and B into one sorted frame.
// Latency: 1 cycle from input handshake to o_vld; 1 element/cycle sustained.
// Backpressure: o_rdy low holds the output register and stalls both inputs.
// Ports:
//   i_clk, i_rst         clock, synchronous active-low reset
//   i_a_* / i_b_*        input element streams (vld/rdy/data/last)
//   o_vld/o_rdy/o_data/o_last  merged output stream (registered)
module cm_merge
  import cm_merge_pkg::*;
#(
  parameter u32 DWIDTH  = CM_DWIDTH_DEF,
  parameter u32 DESCEND = CM_DESCEND_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_vld,
  output logic              i_a_rdy,
  input  logic [DWIDTH-1:0] i_a_data,
  input  logic              i_a_last,
  input  logic              i_b_vld,
  output logic              i_b_rdy,
  input  logic [DWIDTH-1:0] i_b_data,
  input  logic              i_b_last,
  output logic              o_vld,
  input  logic              o_rdy,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_last
);

  state_t              state;
  state_t              state_nxt;
  logic                ld;
  logic                pick_a;
  logic                a_rdy;
  logic                b_rdy;
  logic                acc_a;
  logic                acc_b;
  logic [DWIDTH-1:0]   ld_data;
  logic                ld_last;

  // Output register can take a new element when empty or being read this cycle.
  assign ld = ~o_vld | o_rdy;

  cm_merge_cmp #(
    .DWIDTH  (DWIDTH),
    .DESCEND (DESCEND)
  ) u_cmp (
    .a      (i_a_data),
    .b      (i_b_data),
    .pick_a (pick_a)
  );

  // Ready, next-state and register load values.
  always_comb begin
    a_rdy     = 1'b0;
    b_rdy     = 1'b0;
    state_nxt = state;
    ld_last   = 1'b0;

    case (state)
      MERGE: begin
        // Only compare when both heads are present: picking early could emit
        // an element that a not-yet-arrived head should have preceded.
        if (i_a_vld && i_b_vld && ld) begin
          if (pick_a) begin
            a_rdy = 1'b1;
          end else begin
            b_rdy = 1'b1;
          end
        end
      end
      DRAIN_A: begin
        a_rdy   = ld;
        ld_last = i_a_last;
      end
      DRAIN_B: begin
        b_rdy   = ld;
        ld_last = i_b_last;
      end
      default: begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
      end
    endcase

    // Nothing is accepted while reset is held, so no element leaks across it.
    if (!i_rst) begin
      a_rdy = 1'b0;
      b_rdy = 1'b0;
    end

    acc_a = a_rdy & i_a_vld;
    acc_b = b_rdy & i_b_vld;

    case (state)
      MERGE: begin
        // The stream that just finished leaves the other one to drain.
        if (acc_a && i_a_last) begin
          state_nxt = DRAIN_B;
        end else if (acc_b && i_b_last) begin
          state_nxt = DRAIN_A;
        end
      end
      DRAIN_A: begin
        if (acc_a && i_a_last) begin
          state_nxt = MERGE;
        end
      end
      DRAIN_B: begin
        if (acc_b && i_b_last) begin
          state_nxt = MERGE;
        end
      end
      default: begin
        state_nxt = MERGE;
      end
    endcase

    ld_data = acc_a ? i_a_data : i_b_data;
  end

  assign i_a_rdy = a_rdy;
  assign i_b_rdy = b_rdy;

  // State and output register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state  <= MERGE;
      o_vld  <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld) begin
        o_vld <= acc_a | acc_b;
        if (acc_a || acc_b) begin
          o_data <= ld_data;
          o_last <= ld_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_cm_merge.sv
// Self-checking bench for cm_merge: one ascending and one descending instance,
// selected by dsel, driven frame by frame against a list-merge reference model.
module tb_cm_merge;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dsel;
  logic       a_vld, a_last, b_vld, b_last, o_rdy;
  logic [7:0] a_dat, b_dat;

  logic       a_rdy0, a_rdy1, b_rdy0, b_rdy1;
  logic       o_vld0, o_vld1, o_last0, o_last1;
  logic [7:0] o_dat0, o_dat1;

  logic       a_rdy, b_rdy, o_vld, o_last;
  logic [7:0] o_dat;

  assign a_rdy  = dsel ? a_rdy1  : a_rdy0;
  assign b_rdy  = dsel ? b_rdy1  : b_rdy0;
  assign o_vld  = dsel ? o_vld1  : o_vld0;
  assign o_last = dsel ? o_last1 : o_last0;
  assign o_dat  = dsel ? o_dat1  : o_dat0;

  cm_merge #(.DWIDTH(8), .DESCEND(0)) u_asc (
    .i_clk(clk), .i_rst(rst),
    .i_a_vld(a_vld & ~dsel), .i_a_rdy(a_rdy0), .i_a_data(a_dat), .i_a_last(a_last),
    .i_b_vld(b_vld & ~dsel), .i_b_rdy(b_rdy0), .i_b_data(b_dat), .i_b_last(b_last),
    .o_vld(o_vld0), .o_rdy(o_rdy), .o_data(o_dat0), .o_last(o_last0)
  );

  cm_merge #(.DWIDTH(8), .DESCEND(1)) u_desc (
    .i_clk(clk), .i_rst(rst),
    .i_a_vld(a_vld & dsel), .i_a_rdy(a_rdy1), .i_a_data(a_dat), .i_a_last(a_last),
    .i_b_vld(b_vld & dsel), .i_b_rdy(b_rdy1), .i_b_data(b_dat), .i_b_last(b_last),
    .o_vld(o_vld1), .o_rdy(o_rdy), .o_data(o_dat1), .o_last(o_last1)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  bit         exp_s[$];   // 0 = element came from A, 1 = from B
  bit         src_q[$];   // sources of accepted, not yet emitted elements

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain merge of two lists by head comparison, ties to A.
  task automatic build_exp();
    int i = 0;
    int j = 0;
    bit take_a;
    exp_d.delete(); exp_l.delete(); exp_s.delete();
    while (i < qa.size() || j < qb.size()) begin
      if (i >= qa.size())      take_a = 1'b0;
      else if (j >= qb.size()) take_a = 1'b1;
      else if (dsel)           take_a = (qa[i] >= qb[j]);
      else                     take_a = (qa[i] <= qb[j]);
      if (take_a) begin exp_d.push_back(qa[i]); exp_s.push_back(1'b0); i++; end
      else        begin exp_d.push_back(qb[j]); exp_s.push_back(1'b1); j++; end
      exp_l.push_back(1'b0);
    end
    exp_l[exp_l.size()-1] = 1'b1;
  endtask

  // rmode: 0 = o_rdy always 1, 1 = 1010 pattern, 2 = random.
  // bgap: B withheld for this many cycles. rst_after: reset after N outputs (-1 = never).
  task automatic run_frame(input int vpct, input int rmode, input int bgap, input int rst_after);
    int na = qa.size();
    int nb = qb.size();
    int ai = 0, bi = 0, oi = 0, cyc = 0;
    bit stall_prev = 1'b0;
    bit acc_a, acc_b, fire, fl, done;
    logic [7:0] held_d, fd;
    bit held_l;
    bit s;
    done = 1'b0;
    src_q.delete();
    build_exp();
    while (!done) begin
      if (rst_after >= 0 && oi >= rst_after) begin
        rst = 1'b0; o_rdy = 1'b0; a_vld = (ai < na); b_vld = (bi < nb);
        @(negedge clk);
        chk("rst_a_rdy", a_rdy, 0);
        chk("rst_b_rdy", b_rdy, 0);
        @(posedge clk); #1;
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; o_rdy = 1'b1;
        @(negedge clk);
        chk("rst_o_vld", o_vld, 0);
        chk("rst_o_data", o_dat, 0);
        chk("rst_o_last", o_last, 0);
        chk("post_rst_a_rdy", a_rdy, 0);
        @(posedge clk); #1;
        return;
      end
      a_vld  = (ai < na) && ($urandom_range(99) < vpct);
      a_dat  = (ai < na) ? qa[ai] : 8'h00;
      a_last = (ai == na - 1);
      b_vld  = (bi < nb) && (cyc >= bgap) && ($urandom_range(99) < vpct);
      b_dat  = (bi < nb) ? qb[bi] : 8'h00;
      b_last = (bi == nb - 1);
      case (rmode)
        0:       o_rdy = 1'b1;
        1:       o_rdy = (cyc % 2 == 0);
        default: o_rdy = ($urandom_range(99) < 60);
      endcase
      @(negedge clk);
      acc_a = a_vld & a_rdy;
      acc_b = b_vld & b_rdy;
      if (acc_a || acc_b) chk("one_acc", acc_a & acc_b, 0);
      if (acc_a || acc_b) begin
        if (ai < na && bi < nb) chk("need_both_vld", a_vld & b_vld, 1);
      end
      if (bgap > 0 && cyc <= bgap) chk("gap_no_out", o_vld, 0);
      if (stall_prev) begin
        chk("hold_vld", o_vld, 1);
        chk("hold_data", o_dat, held_d);
        chk("hold_last", o_last, held_l);
      end
      stall_prev = o_vld & ~o_rdy;
      held_d = o_dat;
      held_l = o_last;
      if (stall_prev && (acc_a || acc_b)) chk("stall_acc", 1, 0);
      fire = o_vld & o_rdy;
      fd   = o_dat;
      fl   = o_last;
      @(posedge clk); #1;
      if (fire) begin
        if (oi >= exp_d.size() || src_q.size() == 0) begin
          chk("extra_out", oi, exp_d.size());
        end else begin
          s = src_q.pop_front();
          chk("data", fd, exp_d[oi]);
          chk("last", fl, exp_l[oi]);
          chk("src", s, exp_s[oi]);
        end
        oi++;
      end
      if (acc_a) begin src_q.push_back(1'b0); ai++; end
      if (acc_b) begin src_q.push_back(1'b1); bi++; end
      cyc++;
      if (oi >= exp_d.size()) begin
        done = 1'b1;
        if (vpct == 100 && rmode == 0 && bgap == 0) chk("cycles", cyc, na + nb + 1);
      end else if (cyc > 400) begin
        chk("timeout", oi, exp_d.size());
        done = 1'b1;
      end
    end
  endtask

  // Random frame: sorted in the current direction unless unsorted is set.
  task automatic gen_frame(input bit unsorted);
    int n;
    int v;
    qa.delete(); qb.delete();
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, 6);
      v = dsel ? 24 : $urandom_range(0, 5);
      for (int e = 0; e < n; e++) begin
        if (unsorted) v = $urandom_range(0, 15);
        if (k == 0) qa.push_back(8'(v)); else qb.push_back(8'(v));
        if (dsel) v = v - $urandom_range(0, 3);
        else      v = v + $urandom_range(0, 3);
      end
    end
  endtask

  initial begin
    rst = 1'b0; dsel = 1'b0; o_rdy = 1'b1;
    a_vld = 1'b0; a_last = 1'b0; a_dat = 8'h00;
    b_vld = 1'b0; b_last = 1'b0; b_dat = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    a_vld = 1'b1; b_vld = 1'b1; a_dat = 8'h03; b_dat = 8'h04;
    @(negedge clk);
    chk("init_o_vld", o_vld, 0);
    chk("init_o_data", o_dat, 0);
    chk("init_o_last", o_last, 0);
    chk("init_a_rdy", a_rdy, 0);
    chk("init_b_rdy", b_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0;

    // Ascending basic, full rate.
    qa = '{8'd1, 8'd4, 8'd7}; qb = '{8'd2, 8'd3, 8'd9};
    run_frame(100, 0, 0, -1);
    // Ties: order A0, A1, B0 with o_last on B0.
    qa = '{8'd5, 8'd5}; qb = '{8'd5};
    run_frame(100, 0, 0, -1);
    // Early exhaustion of B, A drained afterwards.
    qa = '{8'd10}; qb = '{8'd1, 8'd2, 8'd3};
    run_frame(100, 0, 0, -1);
    // Backpressure 1010 on the basic frame.
    qa = '{8'd1, 8'd4, 8'd7}; qb = '{8'd2, 8'd3, 8'd9};
    run_frame(100, 1, 0, -1);
    // Descending with B withheld for 3 cycles.
    dsel = 1'b1;
    qa = '{8'd9, 8'd6}; qb = '{8'd8, 8'd1};
    run_frame(100, 0, 3, -1);
    // Mid-frame reset after two outputs, then a fresh frame.
    dsel = 1'b0;
    qa = '{8'd1, 8'd3, 8'd5, 8'd7}; qb = '{8'd2, 8'd4, 8'd6};
    run_frame(100, 0, 0, 2);
    qa = '{8'd0, 8'd8}; qb = '{8'd4};
    run_frame(100, 0, 0, -1);

    // Randomized frames, both directions, some unsorted.
    for (int t = 0; t < 60; t++) begin
      dsel = $urandom_range(0, 1);
      gen_frame($urandom_range(0, 4) == 0);
      run_frame($urandom_range(50, 100), $urandom_range(0, 2), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
